// File: rtl/mcpu_core_exn_dispatch_if.sv
// mcpu_core_exn_dispatch_if: fetch redirect valid/ready handshake
interface mcpu_core_exn_dispatch_if #(parameter int ADDR_W = 28);
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              redir_ready;
  modport master(output redir_valid, output redir_pc, input redir_ready);
  modport slave(input redir_valid, input redir_pc, output redir_ready);
endinterface

// File: rtl/mcpu_core_exn_dispatch.sv
// mcpu_core_exn_dispatch: exception entry/eret sequencer with control registers and fetch redirect
module mcpu_core_exn_dispatch #(parameter int ADDR_W = 28) (
  input  logic                       clkrst_core_clk,
  input  logic                       clkrst_core_rst,
  input  logic [4:0]                 combined_ec0,
  input  logic [4:0]                 combined_ec1,
  input  logic [4:0]                 combined_ec2,
  input  logic [4:0]                 combined_ec3,
  input  logic                       exception,
  input  logic                       pc_valid,
  input  logic [ADDR_W-1:0]          pc_pc,
  input  logic                       pc_eret,
  input  logic                       cr_we,
  input  logic [1:0]                 cr_sel,
  input  logic [31:0]                cr_wdata,
  output logic [ADDR_W-1:0]          cr_eha,
  output logic [ADDR_W-1:0]          cr_epc,
  output logic [31:0]                cr_ec,
  output logic [1:0]                 cr_flags,
  output logic                       interrupts_enabled,
  output logic                       exn_flush,
  output logic                       exn_busy,
  mcpu_core_exn_dispatch_if.master   redir
);
  localparam logic [4:0] NOERR = 5'd0;
  typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] eha_q, eha_d, epc_q, epc_d, tgt_q, tgt_d;
  logic [6:0]        ec_q, ec_d;
  logic              ie_q, ie_d, sie_q, sie_d;
  logic [1:0]        lane;
  logic [4:0]        code;
  logic              idle, entry, ret, wr;
  // lane 0 has highest priority; all-NOERR falls back to lane 0
  always_comb begin
    lane  = (combined_ec0 != NOERR) ? 2'd0 : (combined_ec1 != NOERR) ? 2'd1 :
            (combined_ec2 != NOERR) ? 2'd2 : (combined_ec3 != NOERR) ? 2'd3 : 2'd0;
    code  = (lane == 2'd0) ? combined_ec0 : (lane == 2'd1) ? combined_ec1 :
            (lane == 2'd2) ? combined_ec2 : combined_ec3;
    idle  = state_q == IDLE;
    entry = idle && exception;
    ret   = idle && pc_eret && pc_valid && !exception;
    wr    = idle && cr_we && !entry && !ret;
  end
  always_comb begin
    state_d = (state_q == IDLE)  ? ((entry || ret) ? FLUSH : IDLE) :
              (state_q == FLUSH) ? REDIR : (redir.redir_ready ? IDLE : REDIR);
    eha_d   = (wr && cr_sel == 2'd0) ? cr_wdata[ADDR_W+3:4] : eha_q;
    epc_d   = entry ? pc_pc : (wr && cr_sel == 2'd1) ? cr_wdata[ADDR_W+3:4] : epc_q;
    ec_d    = entry ? {lane, code} : (wr && cr_sel == 2'd2) ? cr_wdata[6:0] : ec_q;
    ie_d    = entry ? 1'b0 : ret ? sie_q : (wr && cr_sel == 2'd3) ? cr_wdata[0] : ie_q;
    sie_d   = entry ? ie_q : (wr && cr_sel == 2'd3) ? cr_wdata[1] : sie_q;
    tgt_d   = entry ? eha_q : ret ? epc_q : tgt_q;
  end
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      state_q <= IDLE;
      eha_q   <= '0;
      epc_q   <= '0;
      tgt_q   <= '0;
      ec_q    <= {2'b00, NOERR};
      ie_q    <= 1'b0;
      sie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      eha_q   <= eha_d;
      epc_q   <= epc_d;
      tgt_q   <= tgt_d;
      ec_q    <= ec_d;
      ie_q    <= ie_d;
      sie_q   <= sie_d;
    end
  end
  assign cr_eha             = eha_q;
  assign cr_epc             = epc_q;
  assign cr_ec              = {25'b0, ec_q};
  assign cr_flags           = {sie_q, ie_q};
  assign interrupts_enabled = ie_q;
  assign exn_flush          = state_q == FLUSH;
  assign exn_busy           = state_q != IDLE;
  assign redir.redir_valid  = state_q == REDIR;
  assign redir.redir_pc     = tgt_q;
endmodule

// File: tb/tb_mcpu_core_exn_dispatch.sv
// tb_mcpu_core_exn_dispatch: directed scoreboard bench for the exception dispatcher
module tb_mcpu_core_exn_dispatch;
  localparam int ADDR_W = 28;
  localparam logic [4:0] NOERR = 5'd0, INTR = 5'd1, ILL = 5'd2, DATA_PF = 5'd6;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] ec0, ec1, ec2, ec3;
  logic exception, pc_valid, pc_eret, cr_we;
  logic [ADDR_W-1:0] pc_pc, cr_eha, cr_epc;
  logic [1:0] cr_sel, cr_flags;
  logic [31:0] cr_wdata, cr_ec;
  logic ie, exn_flush, exn_busy;
  int n_cmp = 0, n_err = 0;
  logic [ADDR_W-1:0] exp_q[$];
  mcpu_core_exn_dispatch_if #(.ADDR_W(ADDR_W)) rif();
  mcpu_core_exn_dispatch #(.ADDR_W(ADDR_W)) dut (
    .clkrst_core_clk(clk), .clkrst_core_rst(rst),
    .combined_ec0(ec0), .combined_ec1(ec1), .combined_ec2(ec2), .combined_ec3(ec3),
    .exception(exception), .pc_valid(pc_valid), .pc_pc(pc_pc), .pc_eret(pc_eret),
    .cr_we(cr_we), .cr_sel(cr_sel), .cr_wdata(cr_wdata),
    .cr_eha(cr_eha), .cr_epc(cr_epc), .cr_ec(cr_ec), .cr_flags(cr_flags),
    .interrupts_enabled(ie), .exn_flush(exn_flush), .exn_busy(exn_busy), .redir(rif));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clear();
    {ec0, ec1, ec2, ec3} = {4{NOERR}};
    {exception, pc_valid, pc_eret, cr_we} = 4'b0;
    pc_pc = '0; cr_sel = 2'd0; cr_wdata = '0;
  endtask
  task automatic cr_write(input logic [1:0] sel, input logic [31:0] data);
    cr_we = 1'b1; cr_sel = sel; cr_wdata = data;
    tick();
    cr_we = 1'b0;
  endtask
  task automatic fault(input logic [ADDR_W-1:0] pc, input logic [4:0] c0, c1, c2, c3);
    exception = 1'b1; pc_valid = 1'b1; pc_pc = pc;
    ec0 = c0; ec1 = c1; ec2 = c2; ec3 = c3;
  endtask
  task automatic drain(input string tag);
    logic [ADDR_W-1:0] exp;
    int n = 0;
    while (!rif.redir_valid && n < 10) begin tick(); n++; end
    if (!rif.redir_valid) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    chk({tag, "_redir_pc"}, 32'(rif.redir_pc), 32'(exp));
    rif.redir_ready = 1'b1;
    tick();
    chk({tag, "_idle"}, {30'b0, exn_busy, rif.redir_valid}, 32'd0);
  endtask
  initial begin
    clear();
    rif.redir_ready = 1'b1;
    tick(); tick();
    chk("rst_eha", 32'(cr_eha), 0);
    chk("rst_epc", 32'(cr_epc), 0);
    chk("rst_ec", cr_ec, {25'b0, 2'b0, NOERR});
    chk("rst_flags", 32'(cr_flags), 0);
    chk("rst_outs", {28'b0, ie, exn_flush, exn_busy, rif.redir_valid}, 0);
    chk("rst_redir_pc", 32'(rif.redir_pc), 0);
    rst = 1'b0;
    tick();
    cr_write(2'd0, 32'h100 << 4);
    chk("eha_write", 32'(cr_eha), 32'h100);
    // priority: lanes 1 and 3 ILL
    fault(28'h55, NOERR, ILL, NOERR, ILL); exp_q.push_back(28'h100);
    tick(); clear();
    chk("prio_ec_1", cr_ec, {25'b0, 2'd1, ILL});
    drain("prio1");
    fault(28'h66, INTR, DATA_PF, NOERR, NOERR); exp_q.push_back(28'h100);
    tick(); clear();
    chk("prio_ec_0", cr_ec, {25'b0, 2'd0, INTR});
    drain("prio0");
    // cycle-exact entry
    cr_write(2'd3, 32'h1);
    chk("flags_write", {30'b0, cr_flags}, {30'b0, 2'b01});
    chk("ie_out", {31'b0, ie}, 1);
    fault(28'h0ABC, NOERR, NOERR, DATA_PF, NOERR); exp_q.push_back(28'h100);
    tick(); clear();
    chk("ent_n1_flush_busy", {30'b0, exn_flush, exn_busy}, 3);
    chk("ent_n1_valid", {31'b0, rif.redir_valid}, 0);
    chk("ent_epc", 32'(cr_epc), 32'h0ABC);
    chk("ent_ec", cr_ec, {25'b0, 2'd2, DATA_PF});
    chk("ent_flags", 32'(cr_flags), 2);
    tick();
    chk("ent_n2_flush", {31'b0, exn_flush}, 0);
    chk("ent_n2_valid", {31'b0, rif.redir_valid}, 1);
    drain("ent");
    // return path
    cr_write(2'd1, 32'h0AC0 << 4);
    chk("epc_write", 32'(cr_epc), 32'h0AC0);
    pc_valid = 1'b1; pc_eret = 1'b1; pc_pc = 28'h0AC0; exp_q.push_back(28'h0AC0);
    tick(); clear();
    chk("ret_flush", {31'b0, exn_flush}, 1);
    chk("ret_flags", 32'(cr_flags), 3);
    chk("ret_ie", {31'b0, ie}, 1);
    drain("ret");
    // backpressure with ignored events
    rif.redir_ready = 1'b0;
    fault(28'h123, NOERR, NOERR, NOERR, ILL); exp_q.push_back(28'h100);
    tick(); clear();
    tick();
    for (int i = 0; i < 5; i++) begin
      fault(28'h777, ILL, NOERR, NOERR, NOERR);
      cr_we = 1'b1; cr_sel = 2'd0; cr_wdata = 32'h999 << 4;
      tick();
      chk("bp_valid", {31'b0, rif.redir_valid}, 1);
      chk("bp_pc", 32'(rif.redir_pc), 32'h100);
    end
    clear();
    chk("bp_epc", 32'(cr_epc), 32'h123);
    chk("bp_ec", cr_ec, {25'b0, 2'd3, ILL});
    chk("bp_eha", 32'(cr_eha), 32'h100);
    drain("bp");
    // simultaneous entry, eret and EHA write
    cr_write(2'd3, 32'h3);
    fault(28'h321, NOERR, NOERR, ILL, NOERR);
    pc_eret = 1'b1; cr_we = 1'b1; cr_sel = 2'd0; cr_wdata = 32'h200 << 4;
    exp_q.push_back(28'h100);
    tick(); clear();
    chk("sim_flags", 32'(cr_flags), 2);
    chk("sim_epc", 32'(cr_epc), 32'h321);
    chk("sim_eha", 32'(cr_eha), 32'h100);
    drain("sim");
    // asynchronous reset while in REDIR
    rif.redir_ready = 1'b0;
    fault(28'h444, ILL, NOERR, NOERR, NOERR);
    tick(); clear();
    tick();
    chk("ar_valid_pre", {31'b0, rif.redir_valid}, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_outs", {28'b0, ie, exn_flush, exn_busy, rif.redir_valid}, 0);
    chk("ar_redir_pc", 32'(rif.redir_pc), 0);
    chk("ar_eha", 32'(cr_eha), 0);
    chk("ar_epc", 32'(cr_epc), 0);
    chk("ar_ec", cr_ec, 0);
    chk("ar_flags", 32'(cr_flags), 0);
    tick();
    rst = 1'b0;
    rif.redir_ready = 1'b1;
    tick();
    chk("ar_idle", {30'b0, exn_busy, rif.redir_valid}, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
